// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: default sizes and FSM encoding.
package int_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned IDX_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        SERV = 2'b10
    } state_e;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Combinational priority encoder: highest set index wins.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDX   = IDX_DEF
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX-1:0]   idx_c,
    output logic             valid_c
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_c = IDX'(i);
            end
        end
    end

    assign valid_c = |vec_i;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/mask/overrun registers, fixed-priority grant,
// and an IDLE/PEND/SERV handshake with the CPU (ack, eoi).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDX   = IDX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_d,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq,
    output logic [IDX-1:0]   vector,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] mask_q,
    output logic [WIDTH-1:0] ovr
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] ovr_q, ovr_d;
    logic [IDX-1:0]   vector_q, vector_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] served;
    logic [IDX-1:0]   win_idx;
    logic             win_valid;

    prio_enc #(
        .WIDTH (WIDTH),
        .IDX   (IDX)
    ) u_prio_enc (
        .vec_i   (pending_q & mask_q),
        .idx_c   (win_idx),
        .valid_c (win_valid)
    );

    // Next state, grant latch and the one-hot line retired by ack.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        served   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = PEND;
                    vector_d = win_idx;
                end
            end
            PEND: begin
                // Stay here even if the line gets masked: the CPU must see its vector.
                if (ack) begin
                    state_d = SERV;
                    served  = WIDTH'(1) << vector_q;
                end
            end
            SERV: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        irq_d = (state_d == PEND);
    end

    // A new request beats the ack clear; overrun only counts a still-pending bit.
    always_comb begin
        pending_d = (pending_q & ~served) | req;
        ovr_d     = (mask_we ? '0 : ovr_q) | (req & pending_q & ~served);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ovr_q     <= '0;
            mask_q    <= '0;
            vector_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            vector_q  <= vector_d;
            irq_q     <= irq_d;
            if (mask_we) begin
                mask_q <= mask_d;
            end
        end
    end

    assign irq     = irq_q;
    assign vector  = vector_q;
    assign pending = pending_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the CPU-visible protocol.
module tb_int_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned IX = 3;

    logic          clk;
    logic          reset;
    logic [W-1:0]  req;
    logic          mask_we;
    logic [W-1:0]  mask_d;
    logic          ack;
    logic          eoi;
    logic          irq;
    logic [IX-1:0] vector;
    logic [W-1:0]  pending;
    logic [W-1:0]  mask_q;
    logic [W-1:0]  ovr;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model: phase 0 = nothing offered, 1 = offered awaiting ack, 2 = in service.
    int            m_phase;
    logic [W-1:0]  m_pend;
    logic [W-1:0]  m_mask;
    logic [W-1:0]  m_ovr;
    logic [IX-1:0] m_vec;

    int_ctrl #(.WIDTH(W), .IDX(IX)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .ack     (ack),
        .eoi     (eoi),
        .irq     (irq),
        .vector  (vector),
        .pending (pending),
        .mask_q  (mask_q),
        .ovr     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int top_bit(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pend  = '0;
        m_mask  = '0;
        m_ovr   = '0;
        m_vec   = '0;
    endtask

    // Apply one clock edge's worth of protocol rules to the model.
    task automatic model_edge();
        logic [W-1:0] retired;
        int           w;
        retired = '0;
        w = top_bit(m_pend & m_mask);
        if (m_phase == 0 && w >= 0) begin
            m_phase = 1;
            m_vec   = IX'(w);
        end else if (m_phase == 1 && ack) begin
            m_phase = 2;
            retired[m_vec] = 1'b1;
        end else if (m_phase == 2 && eoi) begin
            m_phase = 0;
        end
        m_ovr  = (mask_we ? '0 : m_ovr) | (req & m_pend & ~retired);
        m_pend = (m_pend & ~retired) | req;
        if (mask_we) m_mask = mask_d;
    endtask

    task automatic compare_all();
        check("irq",     32'(irq),     32'(m_phase == 1));
        check("vector",  32'(vector),  32'(m_vec));
        check("pending", 32'(pending), 32'(m_pend));
        check("mask_q",  32'(mask_q),  32'(m_mask));
        check("ovr",     32'(ovr),     32'(m_ovr));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        req     = '0;
        mask_we = 1'b0;
        mask_d  = '0;
        ack     = 1'b0;
        eoi     = 1'b0;
    endtask

    task automatic load_mask(input logic [W-1:0] m);
        mask_we = 1'b1;
        mask_d  = m;
        cycle();
    endtask

    initial begin
        reset   = 1'b0;
        req     = '0;
        mask_we = 1'b0;
        mask_d  = '0;
        ack     = 1'b0;
        eoi     = 1'b0;
        model_reset();
        #3;
        check("rst_irq",     32'(irq),     32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_mask",    32'(mask_q),  32'h0);
        check("rst_vector",  32'(vector),  32'h0);
        check("rst_ovr",     32'(ovr),     32'h0);
        reset = 1'b1;

        // Single top-priority line: two-edge latency, ack clears, eoi returns.
        load_mask(8'h80);
        req = 8'h80; cycle();
        check("s1_irq_n", 32'(irq), 32'h0);
        cycle();
        check("s1_irq_n1", 32'(irq), 32'h1);
        check("s1_vec", 32'(vector), 32'd7);
        ack = 1'b1; cycle();
        check("s1_pend_ack", 32'(pending), 32'h00);
        check("s1_irq_ack", 32'(irq), 32'h0);
        eoi = 1'b1; cycle();
        cycle();
        check("s1_idle_irq", 32'(irq), 32'h0);

        // Two lines at once: highest first, lower one reasserts after eoi.
        load_mask(8'hFF);
        req = 8'h05; cycle();
        cycle();
        check("s2_vec2", 32'(vector), 32'd2);
        check("s2_irq", 32'(irq), 32'h1);
        ack = 1'b1; cycle();
        eoi = 1'b1; cycle();
        check("s2_idle_irq", 32'(irq), 32'h0);
        cycle();
        check("s2_reassert", 32'(irq), 32'h1);
        check("s2_vec0", 32'(vector), 32'd0);
        ack = 1'b1; cycle();
        eoi = 1'b1; cycle();

        // Masked request is recorded but not offered until enabled.
        load_mask(8'h00);
        req = 8'h80; cycle();
        check("s3_pend", 32'(pending), 32'h80);
        check("s3_irq_masked", 32'(irq), 32'h0);
        cycle();
        check("s3_irq_still", 32'(irq), 32'h0);
        load_mask(8'h80);
        check("s3_irq_edge1", 32'(irq), 32'h0);
        cycle();
        check("s3_irq_edge2", 32'(irq), 32'h1);
        ack = 1'b1; cycle();
        eoi = 1'b1; cycle();

        // Overrun on a repeated request, cleared by a mask write.
        req = 8'h80; cycle();
        req = 8'h80; cycle();
        check("s4_ovr", 32'(ovr), 32'h80);
        load_mask(8'h80);
        check("s4_ovr_clr", 32'(ovr), 32'h00);
        ack = 1'b1; cycle();
        eoi = 1'b1; cycle();

        // No preemption; a request on the acked line survives the ack.
        load_mask(8'hFF);
        req = 8'h08; cycle();
        cycle();
        check("s5_vec3", 32'(vector), 32'd3);
        req = 8'h80; cycle();
        check("s5_nopreempt", 32'(vector), 32'd3);
        check("s5_irq", 32'(irq), 32'h1);
        ack = 1'b1; req = 8'h08; cycle();
        check("s5_pend_set_wins", 32'(pending), 32'h88);
        check("s5_no_ovr", 32'(ovr), 32'h00);
        eoi = 1'b1; cycle();
        cycle();
        check("s5_vec7", 32'(vector), 32'd7);

        // Asynchronous reset while in service.
        ack = 1'b1; cycle();
        check("s6_in_serv_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        #1;
        check("s6_irq",     32'(irq),         32'h0);
        check("s6_pending", 32'(pending),     32'h0);
        check("s6_mask",    32'(mask_q),      32'h0);
        check("s6_vector",  32'(vector),      32'h0);
        check("s6_state",   32'(dut.state_q), 32'h0);
        model_reset();
        reset = 1'b1;
        cycle();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            req     = ($urandom_range(0, 2) == 0) ? W'($urandom & $urandom) : '0;
            mask_we = ($urandom_range(0, 15) == 0);
            mask_d  = W'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 2) == 0);
            if (k % 700 == 350) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                reset = 1'b1;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
